booth_r4_seq_mult: RTL and testbench

Sequential radix-4 Booth multiplier controller. It multiplies two signed WIDTH-bit operands by sequencing one Booth recoding step per clock: 2 multiplier bits per step, WIDTH/2 steps in total. Each step recodes the current 3-bit window into {neg, A, 2A} controls and accumulates the selected partial product. The block sits between an operand producer and a result consumer, with a valid/ready handshake on both sides. It trades throughput for area against the array multiplier.

---
 rtl/booth_r4_seq_mult.sv | 175 +++++++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - sequential radix-4 Booth multiplier with valid/ready handshakes
//
// Multiplies two signed WIDTH-bit operands, retiring two multiplier bits per
// clock (WIDTH/2 steps), and presents the signed 2*WIDTH-bit product.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset, priority over everything
//   in_valid     operand pair available
//   in_ready     block can accept operands (IDLE only)
//   multiplicand signed operand A, sampled on the accept edge
//   multiplier   signed operand B, sampled on the accept edge
//   out_valid    product available (DONE only)
//   out_ready    consumer takes the product
//   product      signed A*B, held stable while out_valid is high
//   busy         high in RUN or DONE
module booth_r4_seq_mult #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH/2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_prev;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] step;

  // Recoding and accumulate datapath
  logic [2:0]    win;
  logic          sel_a;
  logic          sel_2a;
  logic          neg;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] a2_ext;
  logic [PW-1:0] pp_mag;
  logic [PW-1:0] pp_shift;
  logic [PW-1:0] addend;
  logic [PW-1:0] acc_sum;
  logic [CNT_W:0] shamt;

  assign win    = {q_reg[1], q_reg[0], q_prev};
  assign a_ext  = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
  // 2A keeps one extra significant bit, so A = -2^(WIDTH-1) still fits exactly.
  assign a2_ext = {{(WIDTH-1){a_reg[WIDTH-1]}}, a_reg, 1'b0};
  assign shamt  = {step, 1'b0};

  always_comb begin
    sel_a  = 1'b0;
    sel_2a = 1'b0;
    neg    = 1'b0;
    case (win)
      3'b001, 3'b010: sel_a = 1'b1;
      3'b011:         sel_2a = 1'b1;
      3'b100: begin
        sel_2a = 1'b1;
        neg    = 1'b1;
      end
      3'b101, 3'b110: begin
        sel_a = 1'b1;
        neg   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (sel_2a) begin
      pp_mag = a2_ext;
    end else if (sel_a) begin
      pp_mag = a_ext;
    end else begin
      pp_mag = '0;
    end
    pp_shift = pp_mag << shamt;
    // Subtraction: invert here, the +1 enters as the adder carry-in.
    addend   = neg ? ~pp_shift : pp_shift;
    acc_sum  = acc + addend + {{(PW-1){1'b0}}, neg};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; the handshake outputs depend on the registered state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (step == LAST_STEP) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      q_reg   <= '0;
      q_prev  <= 1'b0;
      acc     <= '0;
      step    <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= multiplicand;
            q_reg  <= multiplier;
            q_prev <= 1'b0;
            acc    <= '0;
            step   <= '0;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          q_prev <= q_reg[1];
          q_reg  <= {{2{q_reg[WIDTH-1]}}, q_reg[WIDTH-1:2]};
          step   <= step + CNT_W'(1);
          if (step == LAST_STEP) begin
            product <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - self-checking bench for booth_r4_seq_mult
module tb_booth_r4_seq_mult;

  localparam int W  = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  booth_r4_seq_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[PW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One multiply with out_ready held high; called at a negedge with the block idle.
  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int lat;
    out_ready = 1'b1;
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_idle"}, 64'(in_ready), 64'd1);
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid     = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
    end
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_product"}, 64'(product), 64'(ref_mul(a, b)));
    @(negedge clk);
    check({tag, "_pulse"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    logic [PW-1:0] held;
    logic [W-1:0]  ra, rb;
    logic [PW-1:0] exp_q[$];
    int            lat;
    int            accepts;
    int            done;
    int            last_acc;
    int            cyc;

    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    check("reset_product", 64'(product), 64'd0);

    // Directed operand patterns
    mult(16'd3, 16'd5, "3x5");
    mult(16'h8000, 16'h8000, "min_x_min");
    mult(16'h8000, 16'h7FFF, "min_x_max");
    mult(16'hFFF9, 16'h9A35, "m7_x_9a35");
    mult(16'h0000, 16'h7FFF, "zero_x_max");
    mult(16'h7FFF, 16'h7FFF, "max_x_max");
    mult(16'hFFFF, 16'h8000, "m1_x_min");
    for (int i = 0; i < 4; i++) begin
      mult(W'($urandom), W'($urandom), "rand");
    end

    // Back-pressure: result held, no new operand consumed
    out_ready    = 1'b0;
    multiplicand = 16'd1234;
    multiplier   = 16'hFDC9;
    in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd8);
    held = ref_mul(16'd1234, 16'hFDC9);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid     = 1'b1;
        multiplicand = 16'd7;
        multiplier   = 16'd7;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_hold", 64'({out_valid, in_ready, product}), 64'({1'b1, 1'b0, held}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    @(negedge clk);
    check("bp_no_stale", 64'({in_ready, out_valid, busy}), 64'(3'b100));

    // Reset at step 4 of a run
    multiplicand = 16'd100;
    multiplier   = 16'hFFFD;
    in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    check("rst_mid_product", 64'(product), 64'd0);
    mult(16'd6, 16'hFFF7, "6_x_m9");

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    accepts   = 0;
    done      = 0;
    last_acc  = -1;
    cyc       = 0;
    while (done < 1000 && cyc < 20000) begin
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          check("b2b_product", 64'(product), 64'(exp_q.pop_front()));
        end else begin
          check("b2b_unexpected", 64'(out_valid), 64'd0);
        end
        done++;
      end
      if (in_ready && accepts < 1000) begin
        ra = W'($urandom);
        rb = W'($urandom);
        multiplicand = ra;
        multiplier   = rb;
        exp_q.push_back(ref_mul(ra, rb));
        if (last_acc >= 0) begin
          check("b2b_interval", 64'(cyc - last_acc), 64'd10);
        end
        last_acc = cyc;
        accepts++;
      end else begin
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        in_valid     = (accepts < 1000);
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_count", 64'(done), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
